// File: rtl/dvp_tx.sv
// DVP byte-stream transmitter: frames RGB565 pixels into vsync/href/byte timing (optional colour bars under DVP_TX_PATTERN_EN).
// Latency: every output is a register; a buffered pixel appears on o_data on the even-slot edge that pops it.
// Backpressure: one-entry pixel buffer; o_ready is high while it is empty (low for a colour-bar frame); empty at an even slot gives an underrun.
module dvp_tx #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 16,
  parameter int VS_LEAD  = 4,
  parameter int V_BLANK  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_pattern,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_frame_start,
  output logic        o_underrun,
  output logic [9:0]  o_line
);

  localparam int LINE_BYTES = 2 * H_ACTIVE;
  localparam int M1   = (LINE_BYTES > H_BLANK) ? LINE_BYTES : H_BLANK;
  localparam int M2   = (M1 > VS_LEAD) ? M1 : VS_LEAD;
  localparam int CMAX = (M2 > V_BLANK) ? M2 : V_BLANK;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VLEAD,
    S_LINE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      line_q, line_d;
  logic            buf_vld_q, buf_vld_d;
  logic [15:0]     buf_dat_q, buf_dat_d;
  logic [7:0]      lo_q, lo_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            fs_q, fs_d;
  logic            ur_q, ur_d;
  logic            push;

`ifdef DVP_TX_PATTERN_EN
  logic            pat_q, pat_d;
  logic [CW-1:0]   col;
  logic [2:0]      bar_sel;
  logic [15:0]     bar_pix;

  assign o_ready = ~buf_vld_q & ~pat_q;
`else
  logic            unused_pattern;

  assign unused_pattern = i_pattern;
  assign o_ready        = ~buf_vld_q;
`endif

  assign push = i_valid & o_ready;

  // Frame sequencer: cnt counts cycles spent in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_enable) state_d = S_VLEAD;
      end
      S_VLEAD: begin
        if (cnt_q == CW'(VS_LEAD - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt_q == CW'(LINE_BYTES - 1)) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end
      end
      S_HBLANK: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (line_q == 10'(V_ACTIVE - 1)) begin
            state_d = S_VBLANK;
          end else begin
            state_d = S_LINE;
            line_d  = line_q + 10'd1;
          end
        end
      end
      S_VBLANK: begin
        if (cnt_q == CW'(V_BLANK - 1)) begin
          cnt_d   = '0;
          state_d = i_enable ? S_VLEAD : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == S_VLEAD) line_d = '0;
  end

`ifdef DVP_TX_PATTERN_EN
  // Colour bar for the pixel column about to be sent.
  always_comb begin
    col     = {1'b0, cnt_d[CW-1:1]};
    bar_sel = 3'(col / CW'(H_ACTIVE / 8));
    case (bar_sel)
      3'd0:    bar_pix = 16'hFFFF;
      3'd1:    bar_pix = 16'hFFE0;
      3'd2:    bar_pix = 16'h07FF;
      3'd3:    bar_pix = 16'h07E0;
      3'd4:    bar_pix = 16'hF81F;
      3'd5:    bar_pix = 16'hF800;
      3'd6:    bar_pix = 16'h001F;
      default: bar_pix = 16'h0000;
    endcase
  end
`endif

  // Output bytes and pixel buffer, derived from the state being entered.
  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_dat_d = buf_dat_q;
    lo_d      = lo_q;
    data_d    = 8'h00;
    ur_d      = 1'b0;
    vsync_d   = (state_d == S_VLEAD) || (state_d == S_LINE) || (state_d == S_HBLANK);
    href_d    = (state_d == S_LINE);
    fs_d      = (state_d == S_VLEAD) && (state_q != S_VLEAD);
`ifdef DVP_TX_PATTERN_EN
    pat_d     = pat_q;
    if (fs_d) pat_d = i_pattern;
    else if (state_d == S_IDLE) pat_d = 1'b0;
`endif
    if (state_d == S_LINE) begin
      if (!cnt_d[0]) begin
`ifdef DVP_TX_PATTERN_EN
        if (pat_q) begin
          data_d = bar_pix[15:8];
          lo_d   = bar_pix[7:0];
        end else
`endif
        if (buf_vld_q) begin
          data_d    = buf_dat_q[15:8];
          lo_d      = buf_dat_q[7:0];
          buf_vld_d = 1'b0;
        end else begin
          data_d = 8'h00;
          lo_d   = 8'h00;
          ur_d   = 1'b1;
        end
      end else begin
        data_d = lo_q;
      end
    end
    // A push only happens into an empty buffer, so it never collides with a pop.
    if (push) begin
      buf_vld_d = 1'b1;
      buf_dat_d = i_data;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      line_q    <= '0;
      buf_vld_q <= 1'b0;
      buf_dat_q <= '0;
      lo_q      <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
`ifdef DVP_TX_PATTERN_EN
      pat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      buf_vld_q <= buf_vld_d;
      buf_dat_q <= buf_dat_d;
      lo_q      <= lo_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
`ifdef DVP_TX_PATTERN_EN
      pat_q     <= pat_d;
`endif
    end
  end

  assign o_vsync       = vsync_q;
  assign o_href        = href_q;
  assign o_data        = data_q;
  assign o_frame_start = fs_q;
  assign o_underrun    = ur_q;
  assign o_line        = line_q;

endmodule
